wb_grf_arbiter: RTL and testbench
=================================

# wb_grf_arbiter

Shares the single GRF write port between the pipeline write-back stage and an auxiliary multi-cycle result source, such as a multi-cycle MD unit that writes GPRs. Pipeline write-back always wins the port. Auxiliary results wait in a 2-entry FIFO and drain into idle write-back slots. The block sits between the WB stage outputs and the GRF write inputs, and exports a pending-register mask and a starvation stall request to the hazard unit.

## Interface
- STARVE_LIMIT, 4: cycles a valid FIFO head may wait ungranted before a stall is requested (range 1..15).
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- regWriteAddr_WB  in  5  pipeline WB destination; 0 means no write.
- regWriteData_WB  in  32  pipeline WB write data.
- PC_WB  in  32  PC of the WB instruction.
- aux_valid  in  1  auxiliary result offered.
- aux_ready  out  1  FIFO can accept; registered-state function, equal to count<2.
- aux_addr  in  5  auxiliary destination register.
- aux_data  in  32  auxiliary result.
- aux_pc  in  32  PC of the producing instruction.
- regWriteAddr_GRF  out  5  GRF write address; 0 means no write.
- regWriteData_GRF  out  32  GRF write data.
- PC_GRF  out  32  PC reported with the write.
- pendMask  out  32  bit r is set iff a valid FIFO entry targets r; bit 0 is always 0.
- stall_pipe  out  1  registered request to insert a WB bubble.

## Operation
- FIFO entry fields: valid, addr, data, pc. Two slots, with a head pointer and a 2-bit count.
- Enqueue:
  - Happens when aux_valid && aux_ready.
  - aux_addr==0 is accepted (handshake completes) but nothing is stored.
  - No enqueue when count==2, even if a dequeue happens in the same cycle.
- Port grant, evaluated combinationally each cycle:
  - regWriteAddr_WB!=0: the pipeline owns the port. Outputs are the WB inputs unchanged.
  - Otherwise, if the head is valid: the head drives the outputs and is dequeued at the clock edge.
  - Otherwise: outputs are addr=0, data=0, PC_GRF=PC_WB.
- Invalid head: popped in any cycle regardless of pipeline activity, with no GRF write.
- Kill rule:
  - When the pipeline writes register R, every stored valid entry with addr==R is cleared at that edge, because the pipeline write is architecturally younger.
  - An entry enqueued in the same cycle is not killed.
- Starvation:
  - wait_cnt increments each cycle the head is valid and ungranted, saturating at 15.
  - wait_cnt clears on grant, when the head becomes invalid, or when the FIFO is empty.
  - stall_pipe is registered to 1 when wait_cnt>=STARVE_LIMIT at the edge.
  - stall_pipe clears at the edge where the head is granted or killed.
- pendMask is combinational from stored entries only.

## Timing
- Reset asserted (asynchronous): count=0, all entries invalid, wait_cnt=0, stall_pipe=0, aux_ready=1, pendMask=0. While reset is low, regWriteAddr_GRF is forced to 0.
- Pipeline path: zero latency, purely combinational.
- Auxiliary path latency:
  - Minimum 1 cycle: enqueued at edge N, written to the GRF in cycle N+1 if that WB slot is idle.
  - A second entry waits at least one further idle slot.
- aux_ready reflects the count after the previous edge. A dequeue in cycle N raises aux_ready in cycle N+1, not in N.
- stall_pipe rises on the edge after wait_cnt reaches STARVE_LIMIT. The earliest assertion is STARVE_LIMIT+1 cycles after enqueue under continuous WB traffic.
- Reset deasserted mid-operation: FIFO contents are lost by design. The upstream unit is reset by the same signal.

## Test plan
- Idle pass-through: WB addr=5, data=0x1234, PC=0x3000 -> GRF outputs equal the WB inputs in the same cycle; pendMask=0.
- Aux drain:
  - Stimulus: WB idle; enqueue addr=8, data=0xAA at edge N.
  - Required: at edge N, pendMask[8]=1; in cycle N+1, GRF addr=8, data=0xAA, PC=aux_pc; after edge N+1, pendMask=0.
- Full/backpressure:
  - Stimulus: WB busy; enqueue addr=3 then addr=4.
  - Required: aux_ready=0; a third offer is held. When WB goes idle, entries retire in order 3 then 4. aux_ready=1 from the cycle after the first dequeue.
- Kill:
  - Stimulus: queued entry addr=9; WB writes addr=9, data=0x77.
  - Required: GRF gets 0x77; pendMask[9] clears; on the next idle slot, the killed entry produces no write.
- Starvation, STARVE_LIMIT=4:
  - Stimulus: head queued; WB writes nonzero addresses continuously.
  - Required: stall_pipe=1 five cycles after enqueue. Once WB supplies addr=0, the head is written and stall_pipe returns to 0 at that edge.
- Async reset mid-queue:
  - Stimulus: two entries queued; pull reset low between edges.
  - Required: immediately pendMask=0, aux_ready=1, stall_pipe=0, GRF addr=0.

Source files
------------

// File: rtl/wb_grf_arbiter_if.sv
// Bundles the WB-stage, auxiliary-source and GRF-write signals of the GRF write-port arbiter.
// slave modport: arbiter view (WB and aux inputs in; GRF write, aux_ready, pendMask, stall_pipe out).
// master modport: surrounding-pipeline view (the mirror image).
interface wb_grf_arbiter_if;
  logic [4:0]  regWriteAddr_WB;
  logic [31:0] regWriteData_WB;
  logic [31:0] PC_WB;
  logic        aux_valid;
  logic        aux_ready;
  logic [4:0]  aux_addr;
  logic [31:0] aux_data;
  logic [31:0] aux_pc;
  logic [4:0]  regWriteAddr_GRF;
  logic [31:0] regWriteData_GRF;
  logic [31:0] PC_GRF;
  logic [31:0] pendMask;
  logic        stall_pipe;

  modport slave (
    input  regWriteAddr_WB, regWriteData_WB, PC_WB,
    input  aux_valid, aux_addr, aux_data, aux_pc,
    output aux_ready,
    output regWriteAddr_GRF, regWriteData_GRF, PC_GRF,
    output pendMask, stall_pipe
  );

  modport master (
    output regWriteAddr_WB, regWriteData_WB, PC_WB,
    output aux_valid, aux_addr, aux_data, aux_pc,
    input  aux_ready,
    input  regWriteAddr_GRF, regWriteData_GRF, PC_GRF,
    input  pendMask, stall_pipe
  );
endinterface

// File: rtl/wb_grf_arbiter.sv
// Shares the GRF write port: pipeline WB always wins, aux results queue in a 2-entry FIFO and drain into idle WB slots.
// Latency: WB path combinational; aux path at least 1 cycle (enqueue edge N, GRF write in cycle N+1).
// Backpressure: aux_ready = (count < 2) from registered state; a head starved STARVE_LIMIT cycles raises stall_pipe.
// Ports: clk, reset (async, active low), bus (wb_grf_arbiter_if.slave).
module wb_grf_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  wb_grf_arbiter_if.slave bus
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef struct packed {
    logic        valid;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc;
  } entry_t;

  entry_t [1:0] fifo_q;
  logic         head_q;
  logic [1:0]   count_q;
  logic [3:0]   wait_cnt_q;
  logic         stall_q;

  entry_t head_ent;
  logic   head_present;
  logic   head_valid;
  logic   wb_busy;
  logic   grant_aux;
  logic   head_killed;
  logic   pop;
  logic   accept;
  logic   store;
  logic   tail_idx;

  assign head_ent     = fifo_q[head_q];
  assign head_present = (count_q != 2'd0);
  assign head_valid   = head_present && head_ent.valid;
  assign wb_busy      = (bus.regWriteAddr_WB != 5'd0);
  assign grant_aux    = !wb_busy && head_valid;
  assign head_killed  = head_valid && wb_busy && (head_ent.addr == bus.regWriteAddr_WB);
  // Killed entries keep their slot until they reach the head; they are discarded
  // there without touching the GRF, whatever the pipeline is doing.
  assign pop          = head_present && (grant_aux || !head_ent.valid);
  assign accept       = bus.aux_valid && bus.aux_ready;
  // Register 0 is never written, so such results complete the handshake but take no slot.
  assign store        = accept && (bus.aux_addr != 5'd0);
  // Enqueue is impossible at count==2, so head+count mod 2 always names a free slot.
  assign tail_idx     = head_q ^ count_q[0];

  assign bus.aux_ready  = (count_q != 2'd2);
  assign bus.stall_pipe = stall_q;

  logic [4:0]  grf_addr;
  logic [31:0] grf_data;
  logic [31:0] grf_pc;

  always_comb begin
    grf_addr = 5'd0;
    grf_data = 32'd0;
    grf_pc   = bus.PC_WB;
    if (wb_busy) begin
      grf_addr = bus.regWriteAddr_WB;
      grf_data = bus.regWriteData_WB;
      grf_pc   = bus.PC_WB;
    end else if (head_valid) begin
      grf_addr = head_ent.addr;
      grf_data = head_ent.data;
      grf_pc   = head_ent.pc;
    end
  end

  // No GRF write may escape while reset is held, even if WB inputs are live.
  assign bus.regWriteAddr_GRF = reset ? grf_addr : 5'd0;
  assign bus.regWriteData_GRF = grf_data;
  assign bus.PC_GRF           = grf_pc;

  logic [31:0] pend;
  always_comb begin
    pend = 32'd0;
    for (int i = 0; i < 2; i++) begin
      if (fifo_q[i].valid) pend[fifo_q[i].addr] = 1'b1;
    end
    pend[0] = 1'b0;
  end
  assign bus.pendMask = pend;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fifo_q     <= '0;
      head_q     <= 1'b0;
      count_q    <= 2'd0;
      wait_cnt_q <= 4'd0;
      stall_q    <= 1'b0;
    end else begin
      // A pipeline write is younger than anything already queued for the same register.
      for (int i = 0; i < 2; i++) begin
        if (wb_busy && fifo_q[i].valid && (fifo_q[i].addr == bus.regWriteAddr_WB)) begin
          fifo_q[i].valid <= 1'b0;
        end
      end
      if (pop) begin
        fifo_q[head_q].valid <= 1'b0;
        head_q               <= ~head_q;
      end
      // Written last so an entry enqueued alongside a matching WB write survives.
      if (store) begin
        fifo_q[tail_idx] <= '{valid: 1'b1, addr: bus.aux_addr, data: bus.aux_data, pc: bus.aux_pc};
      end
      count_q <= count_q + {1'b0, store} - {1'b0, pop};

      if (!head_valid || grant_aux || head_killed) begin
        wait_cnt_q <= 4'd0;
      end else if (wait_cnt_q != 4'hF) begin
        wait_cnt_q <= wait_cnt_q + 4'd1;
      end

      if (!head_valid || grant_aux || head_killed) begin
        stall_q <= 1'b0;
      end else if (wait_cnt_q >= LIMIT) begin
        stall_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_grf_arbiter.sv
module tb_wb_grf_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  wb_grf_arbiter_if bus ();

  wb_grf_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs are changed here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.regWriteAddr_WB = 5'd0;
    bus.regWriteData_WB = 32'd0;
    bus.PC_WB           = 32'd0;
    bus.aux_valid       = 1'b0;
    bus.aux_addr        = 5'd0;
    bus.aux_data        = 32'd0;
    bus.aux_pc          = 32'd0;
  endtask

  task automatic set_wb(input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
    bus.regWriteAddr_WB = a;
    bus.regWriteData_WB = d;
    bus.PC_WB           = pc;
  endtask

  task automatic offer(input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
    bus.aux_valid = 1'b1;
    bus.aux_addr  = a;
    bus.aux_data  = d;
    bus.aux_pc    = pc;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    tick();
    tick();
    set_wb(5'd7, 32'hDEAD, 32'h10);
    #1;
    checks++; if (bus.regWriteAddr_GRF !== 5'd0) begin failures++; $display("FAIL reset_grf_addr got=%0h exp=0", bus.regWriteAddr_GRF); end
    checks++; if (bus.aux_ready !== 1'b1) begin failures++; $display("FAIL reset_aux_ready got=%0b exp=1", bus.aux_ready); end
    checks++; if (bus.pendMask !== 32'd0) begin failures++; $display("FAIL reset_pendmask got=%0h exp=0", bus.pendMask); end
    checks++; if (bus.stall_pipe !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", bus.stall_pipe); end
    idle_inputs();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_passthrough();
    set_wb(5'd5, 32'h1234, 32'h3000);
    #1;
    checks++; if (bus.regWriteAddr_GRF !== 5'd5) begin failures++; $display("FAIL pass_addr got=%0h exp=5", bus.regWriteAddr_GRF); end
    checks++; if (bus.regWriteData_GRF !== 32'h1234) begin failures++; $display("FAIL pass_data got=%0h exp=1234", bus.regWriteData_GRF); end
    checks++; if (bus.PC_GRF !== 32'h3000) begin failures++; $display("FAIL pass_pc got=%0h exp=3000", bus.PC_GRF); end
    checks++; if (bus.pendMask !== 32'd0) begin failures++; $display("FAIL pass_pendmask got=%0h exp=0", bus.pendMask); end
    tick();
    idle_inputs();
  endtask

  task automatic test_aux_drain();
    set_wb(5'd0, 32'd0, 32'h2000);
    offer(5'd8, 32'hAA, 32'h100);
    #1;
    checks++; if (bus.aux_ready !== 1'b1) begin failures++; $display("FAIL drain_ready got=%0b exp=1", bus.aux_ready); end
    checks++; if (bus.regWriteAddr_GRF !== 5'd0 || bus.PC_GRF !== 32'h2000) begin failures++; $display("FAIL drain_idle_out got=%0h/%0h exp=0/2000", bus.regWriteAddr_GRF, bus.PC_GRF); end
    tick();
    bus.aux_valid = 1'b0;
    #1;
    checks++; if (bus.pendMask !== (32'h1 << 8)) begin failures++; $display("FAIL drain_pend8 got=%0h exp=100", bus.pendMask); end
    checks++; if (bus.regWriteAddr_GRF !== 5'd8) begin failures++; $display("FAIL drain_addr got=%0h exp=8", bus.regWriteAddr_GRF); end
    checks++; if (bus.regWriteData_GRF !== 32'hAA) begin failures++; $display("FAIL drain_data got=%0h exp=aa", bus.regWriteData_GRF); end
    checks++; if (bus.PC_GRF !== 32'h100) begin failures++; $display("FAIL drain_pc got=%0h exp=100", bus.PC_GRF); end
    tick();
    #1;
    checks++; if (bus.pendMask !== 32'd0) begin failures++; $display("FAIL drain_pend_clear got=%0h exp=0", bus.pendMask); end
    checks++; if (bus.regWriteAddr_GRF !== 5'd0 || bus.regWriteData_GRF !== 32'd0) begin failures++; $display("FAIL drain_after got=%0h/%0h exp=0/0", bus.regWriteAddr_GRF, bus.regWriteData_GRF); end
    idle_inputs();
  endtask

  task automatic test_zero_addr();
    offer(5'd0, 32'h55, 32'h150);
    #1;
    checks++; if (bus.aux_ready !== 1'b1) begin failures++; $display("FAIL zero_ready_pre got=%0b exp=1", bus.aux_ready); end
    tick();
    bus.aux_valid = 1'b0;
    #1;
    checks++; if (bus.pendMask !== 32'd0 || bus.regWriteAddr_GRF !== 5'd0) begin failures++; $display("FAIL zero_nostore got=%0h/%0h exp=0/0", bus.pendMask, bus.regWriteAddr_GRF); end
    idle_inputs();
    tick();
  endtask

  task automatic test_backpressure();
    set_wb(5'd1, 32'h11, 32'h400);
    offer(5'd3, 32'h33, 32'h503);
    #1;
    checks++; if (bus.aux_ready !== 1'b1) begin failures++; $display("FAIL bp_ready0 got=%0b exp=1", bus.aux_ready); end
    tick();
    offer(5'd4, 32'h44, 32'h504);
    #1;
    checks++; if (bus.aux_ready !== 1'b1) begin failures++; $display("FAIL bp_ready1 got=%0b exp=1", bus.aux_ready); end
    checks++; if (bus.regWriteAddr_GRF !== 5'd1 || bus.regWriteData_GRF !== 32'h11) begin failures++; $display("FAIL bp_wb_wins got=%0h/%0h exp=1/11", bus.regWriteAddr_GRF, bus.regWriteData_GRF); end
    tick();
    offer(5'd6, 32'h66, 32'h506);
    #1;
    checks++; if (bus.aux_ready !== 1'b0) begin failures++; $display("FAIL bp_full got=%0b exp=0", bus.aux_ready); end
    checks++; if (bus.pendMask !== 32'h18) begin failures++; $display("FAIL bp_pend got=%0h exp=18", bus.pendMask); end
    tick();
    set_wb(5'd0, 32'd0, 32'h410);
    #1;
    checks++; if (bus.regWriteAddr_GRF !== 5'd3 || bus.regWriteData_GRF !== 32'h33) begin failures++; $display("FAIL bp_first got=%0h/%0h exp=3/33", bus.regWriteAddr_GRF, bus.regWriteData_GRF); end
    checks++; if (bus.aux_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_same_cycle got=%0b exp=0", bus.aux_ready); end
    tick();
    #1;
    checks++; if (bus.aux_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_after got=%0b exp=1", bus.aux_ready); end
    checks++; if (bus.regWriteAddr_GRF !== 5'd4 || bus.regWriteData_GRF !== 32'h44 || bus.PC_GRF !== 32'h504) begin failures++; $display("FAIL bp_second got=%0h/%0h/%0h exp=4/44/504", bus.regWriteAddr_GRF, bus.regWriteData_GRF, bus.PC_GRF); end
    tick();
    bus.aux_valid = 1'b0;
    #1;
    checks++; if (bus.regWriteAddr_GRF !== 5'd6 || bus.regWriteData_GRF !== 32'h66) begin failures++; $display("FAIL bp_held_offer got=%0h/%0h exp=6/66", bus.regWriteAddr_GRF, bus.regWriteData_GRF); end
    tick();
    #1;
    checks++; if (bus.pendMask !== 32'd0 || bus.regWriteAddr_GRF !== 5'd0) begin failures++; $display("FAIL bp_empty got=%0h/%0h exp=0/0", bus.pendMask, bus.regWriteAddr_GRF); end
    idle_inputs();
  endtask

  task automatic test_kill();
    set_wb(5'd1, 32'h11, 32'h600);
    offer(5'd9, 32'h99, 32'h609);
    tick();
    bus.aux_valid = 1'b0;
    set_wb(5'd9, 32'h77, 32'h700);
    #1;
    checks++; if (bus.regWriteAddr_GRF !== 5'd9 || bus.regWriteData_GRF !== 32'h77 || bus.PC_GRF !== 32'h700) begin failures++; $display("FAIL kill_wb got=%0h/%0h/%0h exp=9/77/700", bus.regWriteAddr_GRF, bus.regWriteData_GRF, bus.PC_GRF); end
    checks++; if (bus.pendMask !== (32'h1 << 9)) begin failures++; $display("FAIL kill_pend_pre got=%0h exp=200", bus.pendMask); end
    tick();
    set_wb(5'd0, 32'd0, 32'h710);
    #1;
    checks++; if (bus.pendMask !== 32'd0) begin failures++; $display("FAIL kill_pend_clear got=%0h exp=0", bus.pendMask); end
    checks++; if (bus.regWriteAddr_GRF !== 5'd0) begin failures++; $display("FAIL kill_no_write got=%0h exp=0", bus.regWriteAddr_GRF); end
    tick();
    // Same-cycle enqueue to the register WB is writing must survive.
    set_wb(5'd10, 32'h1010, 32'h720);
    offer(5'd10, 32'hA0, 32'h60A);
    #1;
    checks++; if (bus.regWriteAddr_GRF !== 5'd10 || bus.regWriteData_GRF !== 32'h1010) begin failures++; $display("FAIL kill_same_wb got=%0h/%0h exp=a/1010", bus.regWriteAddr_GRF, bus.regWriteData_GRF); end
    tick();
    idle_inputs();
    #1;
    checks++; if (bus.pendMask !== (32'h1 << 10)) begin failures++; $display("FAIL kill_same_survive got=%0h exp=400", bus.pendMask); end
    checks++; if (bus.regWriteAddr_GRF !== 5'd10 || bus.regWriteData_GRF !== 32'hA0) begin failures++; $display("FAIL kill_same_write got=%0h/%0h exp=a/a0", bus.regWriteAddr_GRF, bus.regWriteData_GRF); end
    tick();
    #1;
    checks++; if (bus.pendMask !== 32'd0 || bus.aux_ready !== 1'b1) begin failures++; $display("FAIL kill_final got=%0h/%0b exp=0/1", bus.pendMask, bus.aux_ready); end
  endtask

  task automatic test_starvation();
    set_wb(5'd2, 32'h22, 32'h800);
    offer(5'd12, 32'hC0, 32'h80C);
    tick();
    bus.aux_valid = 1'b0;
    #1;
    checks++; if (bus.stall_pipe !== 1'b0) begin failures++; $display("FAIL starve_e0 got=%0b exp=0", bus.stall_pipe); end
    for (int k = 1; k <= 5; k++) begin
      tick();
      #1;
      checks++;
      if (bus.stall_pipe !== (k == 5)) begin
        failures++;
        $display("FAIL starve_edge%0d got=%0b exp=%0b", k, bus.stall_pipe, (k == 5));
      end
    end
    set_wb(5'd0, 32'd0, 32'h810);
    #1;
    checks++; if (bus.regWriteAddr_GRF !== 5'd12 || bus.regWriteData_GRF !== 32'hC0 || bus.stall_pipe !== 1'b1) begin failures++; $display("FAIL starve_grant got=%0h/%0h/%0b exp=c/c0/1", bus.regWriteAddr_GRF, bus.regWriteData_GRF, bus.stall_pipe); end
    tick();
    #1;
    checks++; if (bus.stall_pipe !== 1'b0 || bus.pendMask !== 32'd0) begin failures++; $display("FAIL starve_release got=%0b/%0h exp=0/0", bus.stall_pipe, bus.pendMask); end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    set_wb(5'd1, 32'h11, 32'h900);
    offer(5'd13, 32'hD0, 32'h90D);
    tick();
    offer(5'd14, 32'hE0, 32'h90E);
    tick();
    bus.aux_valid = 1'b0;
    #1;
    checks++; if (bus.pendMask !== 32'h6000 || bus.aux_ready !== 1'b0) begin failures++; $display("FAIL areset_pre got=%0h/%0b exp=6000/0", bus.pendMask, bus.aux_ready); end
    #1;
    reset = 1'b0;
    #1;
    checks++; if (bus.pendMask !== 32'd0) begin failures++; $display("FAIL areset_pend got=%0h exp=0", bus.pendMask); end
    checks++; if (bus.aux_ready !== 1'b1) begin failures++; $display("FAIL areset_ready got=%0b exp=1", bus.aux_ready); end
    checks++; if (bus.stall_pipe !== 1'b0) begin failures++; $display("FAIL areset_stall got=%0b exp=0", bus.stall_pipe); end
    checks++; if (bus.regWriteAddr_GRF !== 5'd0) begin failures++; $display("FAIL areset_grf got=%0h exp=0", bus.regWriteAddr_GRF); end
    tick();
    idle_inputs();
    reset = 1'b1;
    tick();
    #1;
    checks++; if (bus.regWriteAddr_GRF !== 5'd0 || bus.pendMask !== 32'd0) begin failures++; $display("FAIL areset_lost got=%0h/%0h exp=0/0", bus.regWriteAddr_GRF, bus.pendMask); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_passthrough();
    test_aux_drain();
    test_zero_addr();
    test_backpressure();
    test_kill();
    test_starvation();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
